// File: rtl/afifo_pkg.sv
// Shared constants and helpers for both sides of the async FIFO.
// No logic. The write side reuses clog2 to size its counters.
package afifo_pkg;

    localparam int ADDRSIZE   = 4;
    localparam int DATASIZE   = 8;
    localparam int RD_LAT_MAX = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/afifo_skid_buf.sv
// Ring buffer of DEPTH words exposing head/level. A pushed word is visible one cycle later.
// Pop is ignored while empty. Push into a full ring is a caller error, caught by the assertion.
module afifo_skid_buf
    import afifo_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int W     = 8,
    parameter int CNTW  = clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [W-1:0]    push_dat,
    input  logic            pop_req,
    output logic [W-1:0]    head_dat,
    output logic            head_vld,
    output logic [CNTW-1:0] level
);

    localparam int              PTRW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [PTRW-1:0] LAST = PTRW'(DEPTH - 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] level_q, level_d;
    logic [W-1:0]    hold_q, hold_d;
    logic            pop;

    assign head_vld = (level_q != '0);
    assign pop      = head_vld & pop_req;
    assign level    = level_q;
    // When empty, keep showing the last presented word instead of a stale ring slot.
    assign head_dat = head_vld ? mem_q[rd_ptr_q] : hold_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hold_d   = head_dat;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_q   <= hold_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && level_q == FULL));

endmodule

// File: rtl/afifo_rd_fwft.sv
// Read-side FWFT output stage: issues rinc on credit and lands sync-read data in a skid ring.
// Latency: rempty falling at cycle t gives m_valid at t+RD_LAT+1; one word per cycle sustained.
// Backpressure: credit (held + in-flight) caps draws at RD_LAT+2; m_ready never reaches rinc.
module afifo_rd_fwft
    import afifo_pkg::*;
#(
    parameter  int DATASIZE  = afifo_pkg::DATASIZE,
    parameter  int RD_LAT    = 1,
    localparam int BUF_DEPTH = RD_LAT + 2,
    localparam int CNTW      = clog2(BUF_DEPTH + 1)
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    output logic                rinc,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic [CNTW-1:0]     m_level
);

    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CNTW-1:0]   inflight;
    logic [CNTW-1:0]   credit;
    logic              capture;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNTW'(pipe_q[i]);
        end
    end

    assign credit  = m_level + inflight;
    // Gated by rrst_n so no read is requested while the stage is held in reset.
    assign rinc    = rrst_n & ~rempty & (credit < CNTW'(BUF_DEPTH));
    assign capture = pipe_q[RD_LAT-1];

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = rinc;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    afifo_skid_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (DATASIZE),
        .CNTW  (CNTW)
    ) u_skid (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .push     (capture),
        .push_dat (mem_rdata),
        .pop_req  (m_ready),
        .head_dat (m_data),
        .head_vld (m_valid),
        .level    (m_level)
    );

endmodule

// File: tb/tb_afifo_rd_fwft.sv
// Bench for afifo_rd_fwft at RD_LAT = 1, 2, 3, each with its own upstream FIFO model and scoreboard.
module tb_afifo_rd_fwft;
    import afifo_pkg::*;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : env
        localparam int LAT = g + 1;
        localparam int BD  = LAT + 2;
        localparam int CW  = clog2(BD + 1);

        logic          rst_n;
        logic          rempty = 1'b1;
        logic          rinc;
        logic          m_valid;
        logic          m_ready = 1'b0;
        logic [7:0]    mem_rdata = 8'h00;
        logic [7:0]    m_data;
        logic [CW-1:0] m_level;

        logic [7:0] src[$];      // words sitting in the upstream FIFO
        logic [7:0] exp_q[$];    // words drawn, in draw order, not yet consumed
        int         acc_cyc[$];  // draw cycle of each word in exp_q
        logic [7:0] dl[4] = '{default: 8'h00};
        logic [7:0] acc_word = 8'h00;
        logic [7:0] last_dat = 8'h00;
        bit         acc_pend = 0;
        bit         rdy_rand = 0;
        bit         rdy_fix  = 1;
        bit         hole_en  = 0;
        bit         done     = 0;
        int         cyc      = 0;
        string      tag;

        afifo_rd_fwft #(.DATASIZE(8), .RD_LAT(LAT)) u_dut (
            .rclk      (clk),
            .rrst_n    (rst_n),
            .rempty    (rempty),
            .rinc      (rinc),
            .mem_rdata (mem_rdata),
            .m_valid   (m_valid),
            .m_ready   (m_ready),
            .m_data    (m_data),
            .m_level   (m_level)
        );

        // Upstream FIFO + synchronous-read memory with RD_LAT cycles of latency.
        initial begin
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                for (int i = 3; i > 0; i--) dl[i] = dl[i-1];
                dl[0]     = acc_pend ? acc_word : 8'($urandom);
                acc_pend  = 0;
                mem_rdata = dl[LAT-1];
                rempty    = (src.size() == 0) || (hole_en && $urandom_range(0, 3) == 0);
                m_ready   = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
            end
        end

        // Monitor: credit rule, level, head word and hold behaviour, then handshakes.
        initial begin
            int vis;
            bit rinc_exp;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1) begin
                    vis = 0;
                    foreach (acc_cyc[i]) if (acc_cyc[i] + LAT + 1 <= cyc) vis++;
                    rinc_exp = !rempty && (acc_cyc.size() < BD);
                    chk({tag, " rinc"}, int'(rinc), int'(rinc_exp));
                    chk({tag, " m_level"}, int'(m_level), vis);
                    chk({tag, " m_valid"}, int'(m_valid), int'(vis != 0));
                    if (vis != 0) begin
                        chk({tag, " m_data"}, int'(m_data), int'(exp_q[0]));
                        last_dat = exp_q[0];
                        if (m_ready) begin
                            void'(exp_q.pop_front());
                            void'(acc_cyc.pop_front());
                        end
                    end else begin
                        chk({tag, " m_data hold"}, int'(m_data), int'(last_dat));
                    end
                    if (rinc === 1'b1 && rempty == 1'b0 && src.size() != 0) begin
                        acc_word = src.pop_front();
                        acc_pend = 1;
                        exp_q.push_back(acc_word);
                        acc_cyc.push_back(cyc);
                    end
                end
            end
        end

        task automatic tick();
            @(negedge clk);
            #1;
        endtask

        task automatic assert_reset();
            rst_n = 1'b0;
            src.delete();
            exp_q.delete();
            acc_cyc.delete();
            acc_pend = 0;
            last_dat = 8'h00;
            dl       = '{default: 8'h00};
        endtask

        task automatic release_reset();
            @(posedge clk);
            #2;
            rst_n = 1'b1;
        endtask

        task automatic wait_idle(input string nm);
            bit ok = 0;
            for (int i = 0; i < 100 && !ok; i++) begin
                tick();
                ok = (src.size() == 0 && exp_q.size() == 0);
            end
            chk({tag, " ", nm}, int'(ok), 1);
        endtask

        initial begin
            int t0, first, cnt, cnt2, rf, rl, rc, vf, vl, vc;
            bit ok;
            tag = $sformatf("lat%0d", LAT);

            // Reset with a non-empty FIFO: no reads requested until release.
            assert_reset();
            src.push_back(8'h11);
            src.push_back(8'h22);
            repeat (3) tick();
            chk({tag, " rst rinc"}, int'(rinc), 0);
            chk({tag, " rst m_valid"}, int'(m_valid), 0);
            chk({tag, " rst m_level"}, int'(m_level), 0);
            chk({tag, " rst m_data"}, int'(m_data), 0);
            release_reset();
            #1;
            chk({tag, " rinc after release"}, int'(rinc), 1);
            wait_idle("drain after reset");

            // Single-word latency.
            repeat (2) tick();
            src.push_back(8'hA5);
            t0 = -1; first = -1; cnt = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (t0 < 0 && !rempty) begin
                    t0 = cyc;
                    chk({tag, " rinc at rempty fall"}, int'(rinc), 1);
                end
                if (rinc) cnt++;
                if (first < 0 && m_valid) begin
                    first = cyc;
                    chk({tag, " first word"}, int'(m_data), 8'hA5);
                end
            end
            chk({tag, " latency"}, first - t0, LAT + 1);
            chk({tag, " single rinc"}, cnt, 1);

            // Streaming 16 words with m_ready held high.
            wait_idle("idle before stream");
            for (int i = 0; i < 16; i++) src.push_back(8'(i));
            rf = -1; rl = -1; rc = 0; vf = -1; vl = -1; vc = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (rinc) begin if (rf < 0) rf = cyc; rl = cyc; rc++; end
                if (m_valid) begin if (vf < 0) vf = cyc; vl = cyc; vc++; end
            end
            chk({tag, " stream rinc count"}, rc, 16);
            chk({tag, " stream rinc span"}, rl - rf, 15);
            chk({tag, " stream valid count"}, vc, 16);
            chk({tag, " stream valid span"}, vl - vf, 15);

            // Backpressure: only BD words drawn while stalled.
            wait_idle("idle before backpressure");
            rdy_fix = 0;
            for (int i = 0; i < 10; i++) src.push_back(8'(8'h40 + i));
            cnt = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (rinc) cnt++;
            end
            chk({tag, " bp rinc pulses"}, cnt, BD);
            chk({tag, " bp m_level"}, int'(m_level), BD);
            chk({tag, " bp rinc held low"}, int'(rinc), 0);
            rdy_fix = 1;
            cnt2 = 0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (rinc) cnt2++;
            end
            chk({tag, " bp total reads"}, cnt + cnt2, 10);
            chk({tag, " bp drained"}, exp_q.size(), 0);

            // Capture and pop in the same cycle at level 1.
            wait_idle("idle before cap/pop");
            rdy_fix = 0;
            src.push_back(8'h3C);
            ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                tick();
                ok = (m_level == 1);
            end
            chk({tag, " level 1 reached"}, int'(ok), 1);
            src.push_back(8'hC3);
            ok = 0;
            for (int i = 0; i < 10 && !ok; i++) begin
                tick();
                ok = (rinc == 1'b1);
            end
            chk({tag, " second read issued"}, int'(ok), 1);
            repeat (LAT - 1) tick();
            rdy_fix = 1;
            tick();
            chk({tag, " cap/pop level before"}, int'(m_level), 1);
            chk({tag, " cap/pop head before"}, int'(m_data), 8'h3C);
            rdy_fix = 0;
            tick();
            chk({tag, " cap/pop level after"}, int'(m_level), 1);
            chk({tag, " cap/pop new head"}, int'(m_data), 8'hC3);
            rdy_fix = 1;

            // Reset mid-stream with words held and in flight.
            wait_idle("idle before mid reset");
            rdy_fix = 0;
            for (int i = 0; i < 12; i++) src.push_back(8'(8'h80 + i));
            ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                tick();
                ok = (m_level == LAT);
            end
            chk({tag, " mid reset level reached"}, int'(ok), 1);
            assert_reset();
            #1;
            chk({tag, " mid reset m_valid"}, int'(m_valid), 0);
            chk({tag, " mid reset m_level"}, int'(m_level), 0);
            chk({tag, " mid reset rinc"}, int'(rinc), 0);
            repeat (2) tick();
            for (int i = 0; i < 4; i++) src.push_back(8'(8'hE0 + i));
            release_reset();
            rdy_fix = 1;
            wait_idle("drain after mid reset");

            // Random traffic with upstream holes and random ready.
            rdy_rand = 1;
            hole_en  = 1;
            for (int i = 0; i < 300; i++) begin
                tick();
                if ($urandom_range(0, 7) == 0) begin
                    cnt = $urandom_range(1, 6);
                    for (int j = 0; j < cnt; j++) src.push_back(8'($urandom));
                end
            end
            rdy_rand = 0;
            hole_en  = 0;
            rdy_fix  = 1;
            wait_idle("random drain");
            done = 1;
        end
    end

    initial begin
        bit all_done;
        all_done = 0;
        for (int i = 0; i < 30000 && !all_done; i++) begin
            @(posedge clk);
            all_done = env[0].done && env[1].done && env[2].done;
        end
        chk("all envs finished", int'(all_done), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
